// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, FSM state encoding and default width.
package alu_pkg;
  localparam int WIDTH_DEFAULT = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  // Low two ctrl bits pick the per-bit function; the upper two invert the operands.
  typedef enum logic [1:0] {ALU_AND = 2'b00, ALU_OR = 2'b01, ALU_ADD = 2'b10, ALU_SLT = 2'b11} alu_op_e;

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice: operand invert muxes, AND/OR/full-add and result select.
module alu_slice
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  logic    inv_a,
  input  logic    inv_b,
  input  alu_op_e op,
  output logic    res,
  output logic    sum,
  output logic    cout
);
  logic aa, bb;

  assign aa   = a ^ inv_a;
  assign bb   = b ^ inv_b;
  assign sum  = aa ^ bb ^ cin;
  assign cout = (aa & bb) | (cin & (aa ^ bb));

  // NOTE: assign a default before the case so every path drives res; no latch is inferred.
  always_comb begin
    res = 1'b0;
    case (op)
      ALU_AND: res = aa & bb;
      ALU_OR:  res = aa | bb;
      ALU_ADD: res = sum;
      default: res = 1'b0;  // SLT: upper bits are zero, bit 0 is patched at the end
    endcase
  end
endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: one bit per cycle, LSB first, with valid/ready request and response.
// Define ALU_SERIAL_OVF_EN to add ovf_o and use overflow-corrected SLT.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
`ifdef ALU_SERIAL_OVF_EN
  output logic             ovf_o,
`endif
  output logic             illegal_o
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, final_res;
  logic             carry_q;
  logic [CW-1:0]    idx_q;
  logic             accept, last_bit, seed;
  logic             bit_res, bit_sum, bit_cout, less_bit;

  assign accept      = (state_q == ST_IDLE) && req_valid_i;
  assign last_bit    = (idx_q == CW'(WIDTH - 1));
  assign seed        = (ctrl_i == OP_SUB) || (ctrl_i == OP_SLT);
  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_DONE);

  alu_slice u_slice (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .inv_a (ctrl_q[3]),
    .inv_b (ctrl_q[2]),
    .op    (alu_op_e'(ctrl_q[1:0])),
    .res   (bit_res),
    .sum   (bit_sum),
    .cout  (bit_cout)
  );

`ifdef ALU_SERIAL_OVF_EN
  logic ovf_bit, ovf_q;
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf_bit  = carry_q ^ bit_cout;
  assign less_bit = bit_sum ^ ovf_bit;
  assign ovf_o    = ovf_q;
`else
  assign less_bit = bit_sum;
`endif

  always_comb begin
    final_res = {bit_res, acc_q[WIDTH-1:1]};
    if (ctrl_q == OP_SLT) final_res[0] = less_bit;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid_i) state_d = is_legal(ctrl_i) ? ST_RUN : ST_DONE;
      ST_RUN:  if (last_bit)    state_d = ST_DONE;
      ST_DONE: if (rsp_ready_i) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: all registered state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: operand/shift registers are reset as well; they are plain flops, not a RAM.
      ctrl_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result_o  <= '0;
      zero_o    <= 1'b1;
      illegal_o <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else if (accept) begin
      ctrl_q  <= ctrl_i;
      a_q     <= src1_i;
      b_q     <= src2_i;
      carry_q <= seed;
      idx_q   <= '0;
      if (!is_legal(ctrl_i)) begin
        result_o  <= '0;
        zero_o    <= 1'b1;
        illegal_o <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
        ovf_q     <= 1'b0;
`endif
      end
    end else if (state_q == ST_RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      acc_q   <= {bit_res, acc_q[WIDTH-1:1]};
      carry_q <= bit_cout;
      idx_q   <= idx_q + 1'b1;
      if (last_bit) begin
        result_o  <= final_res;
        zero_o    <= (final_res == '0);
        illegal_o <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
        ovf_q     <= (ctrl_q[1:0] == ALU_ADD) && ovf_bit;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed corner cases plus randomized ops against a behavioural model.
module tb_alu_serial;
  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef ALU_SERIAL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]   ctrl;
  logic [W-1:0] src1, src2, result;
  logic         zero, illegal;
`ifdef ALU_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  alu_serial #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .ctrl_i      (ctrl),
    .src1_i      (src1),
    .src2_i      (src2),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .result_o    (result),
    .zero_o      (zero),
`ifdef ALU_SERIAL_OVF_EN
    .ovf_o       (ovf),
`endif
    .illegal_o   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic on the operand values, signed range checks for overflow.
  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic z, output logic il, output logic ov);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint lo = -(longint'(1) <<< (W - 1));
    longint hi = (longint'(1) <<< (W - 1)) - 1;
    logic [W-1:0] d = a - b;
    il = 1'b0;
    ov = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; ov = (sa + sb > hi) || (sa + sb < lo); end
      4'b0110: begin r = d;     ov = (sa - sb > hi) || (sa - sb < lo); end
      4'b1100: r = ~(a | b);
      4'b0111: r = OVF_EN ? W'(sa < sb) : W'(d[W-1]);
      default: begin r = '0; il = 1'b1; end
    endcase
    z = (r == '0);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return {W{1'b1}};
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom());
    endcase
  endfunction

  // Starts and ends on a falling edge; returns once rsp_valid is seen or the bound expires.
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int acc_cyc);
    req_valid = 1'b1;
    ctrl = c;
    src1 = a;
    src2 = b;
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    ctrl = 4'($urandom());
    src1 = W'($urandom());
    src2 = W'($urandom());
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    ctrl = '0;
    src1 = '0;
    src2 = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_vec++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero got=%b exp=1", zero); end
    n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
`ifdef ALU_SERIAL_OVF_EN
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  typedef struct {
    string        name;
    logic [3:0]   c;
    logic [W-1:0] a, b, r;
    logic         ov;
  } dir_t;

  task automatic test_directed();
    dir_t d[$];
    int lat, ac;
    d.push_back('{"add_wrap",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1});
    d.push_back('{"slt_neg1",  4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
    d.push_back('{"slt_min",   4'b0111, 32'h8000_0000, 32'h0000_0001, OVF_EN ? 32'h1 : 32'h0, 1'b0});
    d.push_back('{"sub_eq",    4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0});
    d.push_back('{"nor_zero",  4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
    d.push_back('{"and_mix",   4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
    d.push_back('{"or_mix",    4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0});
    d.push_back('{"sub_ovf",   4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1});
    foreach (d[i]) begin
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s req_ready got=%b exp=1", d[i].name, req_ready); end
      do_op(d[i].c, d[i].a, d[i].b, lat, ac);
      n_vec++; if (lat != LAT) begin n_err++; $display("FAIL %s latency got=%0d exp=%0d", d[i].name, lat, LAT); end
      n_vec++; if (result !== d[i].r) begin n_err++; $display("FAIL %s result got=%h exp=%h", d[i].name, result, d[i].r); end
      n_vec++; if (zero !== (d[i].r == '0)) begin n_err++; $display("FAIL %s zero got=%b exp=%b", d[i].name, zero, d[i].r == '0); end
      n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL %s illegal got=%b exp=0", d[i].name, illegal); end
`ifdef ALU_SERIAL_OVF_EN
      if (d[i].c != 4'b0111) begin
        n_vec++; if (ovf !== d[i].ov) begin n_err++; $display("FAIL %s ovf got=%b exp=%b", d[i].name, ovf, d[i].ov); end
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] codes[4] = '{4'b0011, 4'b1111, 4'b1000, 4'b0101};
    int lat, ac;
    foreach (codes[i]) begin
      do_op(codes[i], W'($urandom()), W'($urandom()), lat, ac);
      n_vec++; if (lat != 1) begin n_err++; $display("FAIL illegal_%b latency got=%0d exp=1", codes[i], lat); end
      n_vec++; if (result !== '0) begin n_err++; $display("FAIL illegal_%b result got=%h exp=0", codes[i], result); end
      n_vec++; if (zero !== 1'b1) begin n_err++; $display("FAIL illegal_%b zero got=%b exp=1", codes[i], zero); end
      n_vec++; if (illegal !== 1'b1) begin n_err++; $display("FAIL illegal_%b flag got=%b exp=1", codes[i], illegal); end
`ifdef ALU_SERIAL_OVF_EN
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL illegal_%b ovf got=%b exp=0", codes[i], ovf); end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a = W'($urandom()), b = W'($urandom()), er;
    logic ez, eil, eov;
    int lat, ac;
    model(4'b0010, a, b, er, ez, eil, eov);
    rsp_ready = 1'b0;
    do_op(4'b0010, a, b, lat, ac);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      ctrl = 4'b0001;
      src1 = W'($urandom());
      src2 = W'($urandom());
      @(negedge clk);
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_rsp_valid cyc%0d got=%b exp=1", i, rsp_valid); end
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_req_ready cyc%0d got=%b exp=0", i, req_ready); end
      n_vec++; if (result !== er) begin n_err++; $display("FAIL stall_result cyc%0d got=%h exp=%h", i, result, er); end
      n_vec++; if (zero !== ez) begin n_err++; $display("FAIL stall_zero cyc%0d got=%b exp=%b", i, zero, ez); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_rsp_valid got=%b exp=0", rsp_valid); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_req_ready got=%b exp=1", req_ready); end
    n_vec++; if (result !== er) begin n_err++; $display("FAIL stall_hold_result got=%h exp=%h", result, er); end
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL stall_no_queue got=%b exp=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, er;
    logic [3:0] c;
    logic ez, eil, eov;
    int lat, ac, prev_ac = 0;
    logic [3:0] ops[4] = '{4'b0010, 4'b0110, 4'b1100, 4'b0111};
    foreach (ops[i]) begin
      c = ops[i];
      a = pick_operand();
      b = pick_operand();
      model(c, a, b, er, ez, eil, eov);
      do_op(c, a, b, lat, ac);
      n_vec++; if (result !== er) begin n_err++; $display("FAIL b2b%0d result got=%h exp=%h", i, result, er); end
      if (i > 0) begin
        n_vec++; if (ac - prev_ac != W + 2) begin n_err++; $display("FAIL b2b%0d period got=%0d exp=%0d", i, ac - prev_ac, W + 2); end
      end
      prev_ac = ac;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] a = W'($urandom()), b = W'($urandom()), er;
    logic ez, eil, eov;
    logic seen = 1'b0;
    int lat, ac;
    req_valid = 1'b1;
    ctrl = 4'b0010;
    src1 = a;
    src2 = b;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstrun_rsp_valid got=%b exp=0", rsp_valid); end
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL rstrun_result got=%h exp=0", result); end
    n_vec++; if (zero !== 1'b1) begin n_err++; $display("FAIL rstrun_zero got=%b exp=1", zero); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstrun_req_ready got=%b exp=1", req_ready); end
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstrun_spurious_rsp got=%b exp=0", seen); end
    a = W'($urandom());
    b = W'($urandom());
    model(4'b0110, a, b, er, ez, eil, eov);
    do_op(4'b0110, a, b, lat, ac);
    n_vec++; if (lat != LAT) begin n_err++; $display("FAIL rstrun_next_latency got=%0d exp=%0d", lat, LAT); end
    n_vec++; if (result !== er) begin n_err++; $display("FAIL rstrun_next_result got=%h exp=%h", result, er); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] legal[6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    logic [3:0] c;
    logic [W-1:0] a, b, er;
    logic ez, eil, eov;
    int lat, ac, k;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 7);
      c = (k < 6) ? legal[k] : 4'($urandom());
      a = pick_operand();
      b = pick_operand();
      model(c, a, b, er, ez, eil, eov);
      do_op(c, a, b, lat, ac);
      n_vec++; if (lat != (eil ? 1 : LAT)) begin n_err++; $display("FAIL rnd%0d latency ctrl=%b got=%0d exp=%0d", i, c, lat, eil ? 1 : LAT); end
      n_vec++; if (result !== er) begin n_err++; $display("FAIL rnd%0d result ctrl=%b a=%h b=%h got=%h exp=%h", i, c, a, b, result, er); end
      n_vec++; if (zero !== ez) begin n_err++; $display("FAIL rnd%0d zero got=%b exp=%b", i, zero, ez); end
      n_vec++; if (illegal !== eil) begin n_err++; $display("FAIL rnd%0d illegal got=%b exp=%b", i, illegal, eil); end
`ifdef ALU_SERIAL_OVF_EN
      if (c != 4'b0111) begin
        n_vec++; if (ovf !== eov) begin n_err++; $display("FAIL rnd%0d ovf ctrl=%b got=%b exp=%b", i, c, ovf, eov); end
      end
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
